// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Purpose:
//   Accepts parallel words over a valid/ready handshake, buffers them in a
//   small circular FIFO and shifts each word out one bit at a time on `w`,
//   qualified by `w_valid`. Each bit is held for DIV clock cycles. Words are
//   chained back to back with no idle cycle when the FIFO has more data.
//
// Handshake:
//   A word is accepted on a rising edge where in_valid=1 and in_ready=1.
//   in_ready is !full (combinational from count) and is forced low while clr
//   is high; a full FIFO refuses a push even if a pop happens on that edge.
//   in_data is ignored whenever in_ready=0.
//
// Ports:
//   clk       system clock, rising edge
//   clr       asynchronous active-high reset
//   in_data   parallel word to serialize
//   in_valid  in_data valid this cycle
//   in_ready  FIFO can accept a word this cycle
//   w         serial bit (registered)
//   w_valid   w carries a data bit (registered)
//   busy      shifter active or FIFO non-empty (registered)
//   count     FIFO occupancy, excluding the word in the shifter
// -----------------------------------------------------------------------------
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int DIV       = 1,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       w,
   output logic                       w_valid,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic [DW-1:0]    div_cnt;
   logic [CW-1:0]    count_nxt;

   logic             full;
   logic             push;
   logic             pop;
   logic             bit_done;
   logic             last_bit;
   logic [WIDTH-1:0] head;
   logic             head_first;
   logic [WIDTH-1:0] head_rest;
   logic             shreg_next_bit;
   logic [WIDTH-1:0] shreg_adv;

   // ---------------------------------------------------------------------
   // Handshake and FIFO control
   // ---------------------------------------------------------------------
   always_comb begin
      full     = (count == CW'(DEPTH));
      in_ready = !clr && !full;
      push     = in_valid && in_ready;
   end

   // ---------------------------------------------------------------------
   // Shifter decode. `pop` is the only place the FIFO is drained: from IDLE
   // whenever a word is waiting, or at the end of the last bit of a word so
   // the next word starts on the same edge.
   // ---------------------------------------------------------------------
   always_comb begin
      bit_done  = (div_cnt == DW'(DIV - 1));
      last_bit  = (bit_cnt == BW'(WIDTH - 1));
      pop       = 1'b0;
      state_nxt = state;
      case (state)
         S_IDLE: begin
            pop = (count != '0);
            if (pop) state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            pop = bit_done && last_bit && (count != '0);
            if (bit_done && last_bit && !pop) state_nxt = S_IDLE;
         end
         default: begin
            pop       = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
      count_nxt = count + CW'(push) - CW'(pop);
   end

   // Bit ordering: the shift register always holds the bits not yet driven,
   // aligned so that the next bit sits at the end selected by MSB_FIRST.
   always_comb begin
      head = mem[rd_ptr];
      if (MSB_FIRST) begin
         head_first     = head[WIDTH-1];
         head_rest      = head << 1;
         shreg_next_bit = shreg[WIDTH-1];
         shreg_adv      = shreg << 1;
      end else begin
         head_first     = head[0];
         head_rest      = head >> 1;
         shreg_next_bit = shreg[0];
         shreg_adv      = shreg >> 1;
      end
   end

   // FIFO storage needs no reset; occupancy is tracked by count/pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   // ---------------------------------------------------------------------
   // FIFO pointers, shifter FSM and registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         state   <= S_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
         w       <= IDLE_BIT;
         w_valid <= 1'b0;
         busy    <= 1'b0;
      end else begin
         // Pointers wrap naturally since DEPTH is a power of two.
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         state <= state_nxt;
         busy  <= (state_nxt == S_SHIFT) || (count_nxt != '0);

         case (state)
            S_IDLE: begin
               if (pop) begin
                  shreg   <= head_rest;
                  w       <= head_first;
                  w_valid <= 1'b1;
                  bit_cnt <= '0;
                  div_cnt <= '0;
               end else begin
                  w       <= IDLE_BIT;
                  w_valid <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (bit_done) begin
                  div_cnt <= '0;
                  if (!last_bit) begin
                     bit_cnt <= bit_cnt + BW'(1);
                     w       <= shreg_next_bit;
                     shreg   <= shreg_adv;
                  end else if (pop) begin
                     // Back-to-back word: first bit lands on this edge.
                     bit_cnt <= '0;
                     w       <= head_first;
                     shreg   <= head_rest;
                  end else begin
                     bit_cnt <= '0;
                     w       <= IDLE_BIT;
                     w_valid <= 1'b0;
                  end
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            default: begin
               w       <= IDLE_BIT;
               w_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
